// File: rtl/exception_sequencer.sv
// Exception sequencer: on an accepted arithmetic exception it flushes the pipeline,
// writes the 16-bit saturation value into two register-file bytes, then redirects
// fetch to the instruction after the faulting one. Owns the RF write port while busy.
module exception_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PC_W    = 10,
  parameter logic [2:0]  REG_HI  = 3'd1,
  parameter logic [2:0]  REG_LO  = 3'd2,
  parameter logic [15:0] SAT_POS = 16'h7FFF,
  parameter logic [15:0] SAT_NEG = 16'h8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        exc_code,
  input  logic [PC_W-1:0]   exc_pc,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              busy,
  output logic [7:0]        exc_count
);

  typedef enum logic [2:0] {StIdle, StFlush, StWrHi, StWrLo, StResume} state_e;

  state_e              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
  logic [7:0]          count_q, count_d;
  logic                flush_q, flush_d;
  logic                redirect_q, redirect_d;
  logic                busy_q, busy_d;
  logic                seq_we_q, seq_we_d;
  logic [2:0]          seq_waddr_q, seq_waddr_d;
  logic [DATA_W-1:0]   seq_wdata_q, seq_wdata_d;
  logic [15:0]         sat;

  // Saturation value chosen by the latched code (valid from FLUSH onward).
  assign sat = (code_q == 2'b10) ? SAT_NEG : SAT_POS;

  // Next-state, capture of the faulting context, and registered Moore outputs.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    pc_d          = pc_q;
    count_d       = count_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      StIdle: begin
        if (exc_code == 2'b01 || exc_code == 2'b10) begin
          state_d = StFlush;
          code_d  = exc_code;
          pc_d    = exc_pc;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      StFlush:  state_d = StWrHi;
      StWrHi:   state_d = StWrLo;
      StWrLo:   state_d = StResume;
      StResume: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Restart address updates only on entry to RESUME so it holds elsewhere.
    if (state_d == StResume) redirect_pc_d = pc_q + PC_W'(1);

    flush_d     = (state_d == StFlush);
    redirect_d  = (state_d == StResume);
    busy_d      = (state_d != StIdle);
    seq_we_d    = (state_d == StWrHi) || (state_d == StWrLo);
    seq_waddr_d = 3'd0;
    seq_wdata_d = '0;
    if (state_d == StWrHi) begin
      seq_waddr_d = REG_HI;
      seq_wdata_d = DATA_W'(sat[15:8]);
    end else if (state_d == StWrLo) begin
      seq_waddr_d = REG_LO;
      seq_wdata_d = DATA_W'(sat[7:0]);
    end
  end

  // Single state register; async reset returns to IDLE with all controls low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      code_q        <= 2'b00;
      pc_q          <= '0;
      redirect_pc_q <= '0;
      count_q       <= 8'd0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      busy_q        <= 1'b0;
      seq_we_q      <= 1'b0;
      seq_waddr_q   <= 3'd0;
      seq_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      busy_q        <= busy_d;
      seq_we_q      <= seq_we_d;
      seq_waddr_q   <= seq_waddr_d;
      seq_wdata_q   <= seq_wdata_d;
    end
  end

  // Write-port arbitration: WB passes through only while idle.
  always_comb begin
    rf_we    = busy_q ? seq_we_q    : wb_we;
    rf_waddr = busy_q ? seq_waddr_q : wb_addr;
    rf_wdata = busy_q ? seq_wdata_q : wb_data;
  end

  assign stall       = busy_q;
  assign busy        = busy_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign exc_count   = count_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: reset, both saturation codes, PC wrap,
// held exceptions with WB traffic, mid-sequence reset, reserved code, count saturation.
module tb_exception_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] exc_code;
  logic [9:0] exc_pc;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       stall;
  logic       flush;
  logic       redirect;
  logic [9:0] redirect_pc;
  logic       busy;
  logic [7:0] exc_count;

  int n_checks = 0;
  int n_fail   = 0;

  exception_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .exc_count   (exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Bounded wait for the sequencer to return to idle.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Checks the four busy cycles following an accepted exception.
  task automatic check_seq(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [9:0] rpc);
    tick();
    chk({tag, "_flush"}, {29'd0, flush, stall, busy}, 32'h7);
    chk({tag, "_flush_we"}, {31'd0, rf_we}, 32'd0);
    exc_code = 2'b00;
    tick();
    chk({tag, "_hi"}, {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd1, hi});
    chk({tag, "_hi_ctl"}, {29'd0, flush, stall, redirect}, 32'h2);
    tick();
    chk({tag, "_lo"}, {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd2, lo});
    tick();
    chk({tag, "_resume"}, {20'd0, redirect, stall, rf_we, redirect_pc},
        {20'd0, 1'b1, 1'b1, 1'b0, rpc});
    tick();
    chk({tag, "_after"}, {20'd0, busy, redirect, redirect_pc}, {20'd0, 2'b00, rpc});
  endtask

  initial begin
    // 1: reset state and idle passthrough
    reset = 1'b1; exc_code = 2'b00; exc_pc = 10'h000;
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 8'hA5;
    #1;
    chk("rst_ctl", {28'd0, stall, flush, redirect, busy}, 32'd0);
    chk("rst_count", {24'd0, exc_count}, 32'd0);
    chk("rst_rpc", {22'd0, redirect_pc}, 32'd0);
    chk("rst_pass", {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd5, 8'hA5});
    tick(); tick();
    reset = 1'b0; wb_we = 1'b0;
    tick();

    // 2: positive saturation
    exc_code = 2'b01; exc_pc = 10'h020;
    check_seq("pos", 8'h7F, 8'hFF, 10'h021);
    chk("pos_count", {24'd0, exc_count}, 32'd1);

    // 3: negative saturation with PC wrap
    exc_code = 2'b10; exc_pc = 10'h3FF;
    check_seq("neg", 8'h80, 8'h00, 10'h000);
    chk("neg_count", {24'd0, exc_count}, 32'd2);

    // 4: exception and WB write held for 8 cycles from a fresh reset
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    exc_code = 2'b01; exc_pc = 10'h100;
    wb_we = 1'b1; wb_addr = 3'd7; wb_data = 8'h33;
    tick();
    chk("hold_flush", {20'd0, flush, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 1'b0, 3'd0, 8'h00});
    tick();
    chk("hold_hi", {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd1, 8'h7F});
    tick();
    chk("hold_lo", {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd2, 8'hFF});
    tick();
    chk("hold_resume", {20'd0, redirect, rf_we, redirect_pc}, {20'd0, 2'b10, 10'h101});
    for (int i = 0; i < 4; i++) tick();
    exc_code = 2'b00; wb_we = 1'b0;
    wait_idle("hold_idle");
    chk("hold_count", {24'd0, exc_count}, 32'd2);

    // 5: async reset during WR_HI
    exc_code = 2'b01; exc_pc = 10'h050;
    tick();
    exc_code = 2'b00;
    tick();
    chk("mid_hi", {20'd0, rf_we, rf_waddr, rf_wdata}, {20'd0, 1'b1, 3'd1, 8'h7F});
    #1 reset = 1'b1;
    #1;
    chk("mid_rst", {26'd0, busy, stall, rf_we, flush, redirect, 1'b0}, 32'd0);
    chk("mid_rst_count", {24'd0, exc_count}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_quiet", {29'd0, rf_we, redirect, busy}, 32'd0);
    end

    // 6: reserved code ignored, then count saturation
    exc_code = 2'b11; exc_pc = 10'h077;
    tick(); tick(); tick();
    chk("rsvd_idle", {30'd0, busy, flush}, 32'd0);
    chk("rsvd_count", {24'd0, exc_count}, 32'd0);
    for (int i = 0; i < 260; i++) begin
      exc_code = 2'b01; exc_pc = 10'(i);
      tick();
      exc_code = 2'b00;
      wait_idle("sat_idle");
      if (i == 254) chk("sat_255", {24'd0, exc_count}, 32'hFF);
    end
    chk("sat_hold", {24'd0, exc_count}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
